// File: rtl/instruction_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Contents:
//   microcode_cycle - two-phase register-file slot marker
//   reg_type        - register-file bus selector (REG_ALU is the no-op target)
//   reg_inc_type    - register increment selector (REG_NONE is idle)
//   microcode_op    - one microcode table word
//   seq_state       - sequencer FSM states
//   opcode / microcode address constants used by the decoder and sequencer
package instruction_sequencer_pkg;

  typedef enum logic [1:0] {
    CYCLE_NONE      = 2'd0,
    CYCLE_REG_FETCH = 2'd1,
    CYCLE_REG_WRITE = 2'd2
  } microcode_cycle;

  typedef enum logic [2:0] {
    REG_A     = 3'd0,
    REG_X     = 3'd1,
    REG_Y     = 3'd2,
    REG_SP    = 3'd3,
    REG_MEM   = 3'd4,
    REG_IMM   = 3'd5,
    REG_FLAGS = 3'd6,
    REG_ALU   = 3'd7
  } reg_type;

  typedef enum logic [1:0] {
    REG_NONE   = 2'd0,
    REG_INC_PC = 2'd1,
    REG_INC_SP = 2'd2,
    REG_DEC_SP = 2'd3
  } reg_inc_type;

  typedef struct packed {
    reg_type     bus_in;
    reg_type     bus_out;
    reg_inc_type inc;
    logic        inc_pc;
    logic        transfer_np;
    logic        last;
  } microcode_op;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_UFETCH   = 3'd2,
    ST_UWRITE   = 3'd3,
    ST_BOUNDARY = 3'd4,
    ST_HALT     = 3'd5
  } seq_state;

  localparam microcode_op NOOP_UOP = '{REG_ALU, REG_ALU, REG_NONE, 1'b0, 1'b0, 1'b0};

  localparam logic [11:0] OP_HALT = 12'hFF8;
  localparam logic [11:0] OP_SLP  = 12'hFF9;
  localparam logic [11:0] OP_NOP  = 12'hFFB;

  localparam logic [7:0] INT_UCODE_ADDR = 8'hF0;
  localparam logic [7:0] UCODE_HALT     = 8'hF8;
  localparam logic [7:0] UCODE_NOP      = 8'hFB;

endpackage

// File: rtl/instruction_sequencer_opcode_decoder.sv
// Combinational opcode decoder: maps a 12-bit opcode to its microcode entry
// point and flags the opcodes that park the core (HALT, SLP).
// Ports:
//   opcode     in  12        latched instruction
//   start_addr out UCODE_AW  first microcode address of the routine
//   is_halt    out 1         opcode is HALT or SLP
module instruction_sequencer_opcode_decoder
  import instruction_sequencer_pkg::*;
#(
  parameter int UCODE_AW = 8
) (
  input  logic [11:0]         opcode,
  output logic [UCODE_AW-1:0] start_addr,
  output logic                is_halt
);

  // Ordinary opcodes get a 16-entry routine block selected by the top nibble;
  // the F-page system opcodes have dedicated entries.
  always_comb begin
    is_halt    = 1'b0;
    start_addr = UCODE_AW'({opcode[11:8], 4'h0});
    case (opcode)
      OP_HALT, OP_SLP: begin
        is_halt    = 1'b1;
        start_addr = UCODE_AW'(UCODE_HALT);
      end
      OP_NOP:  start_addr = UCODE_AW'(UCODE_NOP);
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// CPU front end: fetches opcodes from program ROM, steps through their
// microcode one two-phase slot (REG_FETCH, REG_WRITE) per micro-op, and takes
// interrupts / HALT waits at instruction boundaries.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   pc / rom_addr             current pc in, ROM address out (same value)
//   rom_data, rom_valid       opcode and its valid strobe
//   ucode_addr / ucode_word   microcode table address out, table word in
//   irq, interrupt_en         level interrupt request and I flag
//   irq_ack                   one-clock pulse on interrupt entry
//   current_cycle             register-file slot marker
//   bus_input_selector, bus_output_selector, increment_selector
//   increment_pc, transfer_np pc controls, only during REG_WRITE
//   immed                     opcode[7:0] of the current instruction
//   halted                    core parked in HALT/SLP
//   ucode_fault               sticky: a routine ran past MAX_UOPS
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int MAX_UOPS = 16,
  parameter int UCODE_AW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [12:0]         pc,
  output logic [12:0]         rom_addr,
  input  logic [11:0]         rom_data,
  input  logic                rom_valid,
  output logic [UCODE_AW-1:0] ucode_addr,
  input  microcode_op         ucode_word,
  input  logic                irq,
  input  logic                interrupt_en,
  output logic                irq_ack,
  output microcode_cycle      current_cycle,
  output reg_type             bus_input_selector,
  output reg_type             bus_output_selector,
  output reg_inc_type         increment_selector,
  output logic                increment_pc,
  output logic                transfer_np,
  output logic [7:0]          immed,
  output logic                halted,
  output logic                ucode_fault
);

  localparam int CNT_W = (MAX_UOPS > 2) ? $clog2(MAX_UOPS) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_UOPS - 1);

  seq_state            state, state_next;
  logic [11:0]         instr;
  logic [UCODE_AW-1:0] dec_addr;
  logic                dec_halt;
  logic                halt_pending;
  logic [CNT_W-1:0]    count;
  microcode_op         op_q;

  assign rom_addr = pc;

  instruction_sequencer_opcode_decoder #(
    .UCODE_AW (UCODE_AW)
  ) u_opcode_decoder (
    .opcode     (instr),
    .start_addr (dec_addr),
    .is_halt    (dec_halt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr        <= '0;
      immed        <= '0;
      ucode_addr   <= '0;
      count        <= '0;
      op_q         <= NOOP_UOP;
      halt_pending <= 1'b0;
      ucode_fault  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (rom_valid) begin
            instr <= rom_data;
            immed <= rom_data[7:0];
          end
        end
        ST_DECODE: begin
          ucode_addr   <= dec_addr;
          count        <= '0;
          halt_pending <= dec_halt;
        end
        ST_UFETCH: op_q <= ucode_word;
        ST_UWRITE: begin
          if (!op_q.last) begin
            if (count == LAST_COUNT) begin
              ucode_fault <= 1'b1;
            end else begin
              ucode_addr <= ucode_addr + 1'b1;
              count      <= count + 1'b1;
            end
          end
        end
        ST_BOUNDARY: begin
          // Clearing the halt flag on the way into HALT keeps the wake-up
          // pass through BOUNDARY from parking the core again.
          if (halt_pending) begin
            halt_pending <= 1'b0;
          end else if (irq && interrupt_en) begin
            ucode_addr <= UCODE_AW'(INT_UCODE_ADDR);
            count      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next          = state;
    current_cycle       = CYCLE_NONE;
    bus_input_selector  = REG_ALU;
    bus_output_selector = REG_ALU;
    increment_selector  = REG_NONE;
    increment_pc        = 1'b0;
    transfer_np         = 1'b0;
    irq_ack             = 1'b0;
    halted              = 1'b0;
    case (state)
      ST_FETCH:  if (rom_valid) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_UFETCH;
      ST_UFETCH: begin
        // The table is combinational, so its word is passed straight through
        // in this slot and held in op_q for the write slot.
        current_cycle       = CYCLE_REG_FETCH;
        bus_input_selector  = ucode_word.bus_in;
        bus_output_selector = ucode_word.bus_out;
        increment_selector  = ucode_word.inc;
        state_next          = ST_UWRITE;
      end
      ST_UWRITE: begin
        current_cycle       = CYCLE_REG_WRITE;
        bus_input_selector  = op_q.bus_in;
        bus_output_selector = op_q.bus_out;
        increment_selector  = op_q.inc;
        increment_pc        = op_q.inc_pc;
        transfer_np         = op_q.transfer_np;
        if (op_q.last || count == LAST_COUNT) state_next = ST_BOUNDARY;
        else                                  state_next = ST_UFETCH;
      end
      ST_BOUNDARY: begin
        if (halt_pending) begin
          state_next = ST_HALT;
        end else if (irq && interrupt_en) begin
          irq_ack    = 1'b1;
          state_next = ST_UFETCH;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (irq) state_next = ST_BOUNDARY;
      end
      default: state_next = ST_FETCH;
    endcase
  end

endmodule
